// File: rtl/demux_pkg.sv
// Shared widths for the 1-to-4 demux: select width and lane count.
package demux_pkg;
    localparam int SEL_W = 2;
    localparam int N_OUT = 4;
endpackage

// File: rtl/dec_2to4.sv
// 2-to-4 one-hot decoder for the demux lane select.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows s continuously.
module dec_2to4
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] s,
    output logic [N_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            onehot[k] = (s == SEL_W'(k));
        end
    end

endmodule

// File: rtl/demux_1to4.sv
// Steers i onto lane s of d; every other lane is driven to zero.
// Latency: one cycle from the (i, s) sample to d.
// Backpressure: none; a new (i, s) pair is taken on every rising clk.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       i,
    input  logic [SEL_W-1:0]        s,
    output logic [N_OUT*DATA_W-1:0] d
);

    logic [N_OUT-1:0]             onehot;
    logic [N_OUT-1:0][DATA_W-1:0] lane_d;
    logic [N_OUT-1:0][DATA_W-1:0] lane_q;

    dec_2to4 u_dec (
        .s      (s),
        .onehot (onehot)
    );

    // AND-gating keeps unselected lanes at zero without a mux per lane.
    always_comb begin
        lane_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            lane_d[k] = i & {DATA_W{onehot[k]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    // Lane 0 sits in the least significant DATA_W bits of the packed array.
    assign d = lane_q;

endmodule

// File: tb/tb_demux_1to4.sv
// Bench for demux_1to4 at DATA_W=1 and DATA_W=8 with a shift-based reference model.
module tb_demux_1to4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  s;
    logic [0:0]  i1;
    logic [7:0]  i8;
    logic [3:0]  d1;
    logic [31:0] d8;

    logic [3:0]  m1;
    logic [31:0] m8;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] tab8 [4] = '{32'h0000_00A5, 32'h0000_A500, 32'h00A5_0000, 32'hA500_0000};
    logic [3:0]  tab1 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    demux_1to4 #(.DATA_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i1),
        .s     (s),
        .d     (d1)
    );

    demux_1to4 #(.DATA_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i8),
        .s     (s),
        .d     (d8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the selected lane holds i shifted into place, everything else zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= 4'b0;
            m8 <= 32'b0;
        end else begin
            m1 <= 4'({3'b0, i1} << s);
            m8 <= {24'b0, i8} << (8 * s);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_d1", {28'b0, d1}, {28'b0, m1});
        chk("model_d8", d8, m8);
    end

    // Called one time unit after a rising edge; drives just after it and waits one edge.
    task automatic cyc(input logic iv1, input logic [7:0] iv8, input logic [1:0] sv);
        #1;
        i1 = iv1;
        i8 = iv8;
        s  = sv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m1    = 4'b0;
        m8    = 32'b0;
        rst_n = 1'b0;
        i1    = 1'b1;
        i8    = 8'h5A;
        s     = 2'd3;

        #1;
        chk("rst_immediate_d1", {28'b0, d1}, 32'h0);
        chk("rst_immediate_d8", d8, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_d1", {28'b0, d1}, 32'h0);
        chk("rst_hold_d8", d8, 32'h0);

        #1;
        rst_n = 1'b1;
        i1    = 1'b0;
        i8    = 8'h00;
        s     = 2'd0;
        @(posedge clk);
        #1;
        chk("i0_s0_d1", {28'b0, d1}, 32'h0);
        chk("i0_s0_d8", d8, 32'h0);

        cyc(1'b1, 8'h11, 2'd0);
        chk("s0_d1", {28'b0, d1}, 32'h1);
        chk("s0_d8", d8, 32'h0000_0011);
        cyc(1'b1, 8'h11, 2'd1);
        chk("s1_d1", {28'b0, d1}, 32'h2);
        chk("s1_d8", d8, 32'h0000_1100);
        cyc(1'b1, 8'h11, 2'd2);
        chk("s2_d1", {28'b0, d1}, 32'h4);
        chk("s2_d8", d8, 32'h0011_0000);
        cyc(1'b1, 8'h11, 2'd3);
        chk("s3_d1", {28'b0, d1}, 32'h8);
        chk("s3_d8", d8, 32'h1100_0000);
        cyc(1'b0, 8'h00, 2'd2);
        chk("i0_s2_d1", {28'b0, d1}, 32'h0);
        chk("i0_s2_d8", d8, 32'h0);
        cyc(1'b1, 8'hFF, 2'd1);
        chk("ff_s1_d8", d8, 32'h0000_FF00);

        // Select change between edges must not show until the next rising clk.
        #1;
        s = 2'd3;
        #1;
        chk("latency_hold_d1", {28'b0, d1}, 32'h2);
        chk("latency_hold_d8", d8, 32'h0000_FF00);
        @(posedge clk);
        #1;
        chk("latency_new_d1", {28'b0, d1}, 32'h8);
        chk("latency_new_d8", d8, 32'hFF00_0000);

        // Asynchronous reset in the middle of the high phase, released before the next edge.
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_clr_d1", {28'b0, d1}, 32'h0);
        chk("async_clr_d8", d8, 32'h0);
        #1;
        rst_n = 1'b1;
        #2;
        chk("async_released_d1", {28'b0, d1}, 32'h0);
        @(posedge clk);
        #1;
        chk("async_restore_d1", {28'b0, d1}, 32'h8);
        chk("async_restore_d8", d8, 32'hFF00_0000);

        cyc(1'b1, 8'hA5, 2'd2);
        chk("a5_s2_d8", d8, 32'h00A5_0000);
        chk("a5_s2_d1", {28'b0, d1}, 32'h4);

        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 8'hA5, 2'(k));
            chk("sweep_d8", d8, tab8[k]);
            chk("sweep_d1", {28'b0, d1}, {28'b0, tab1[k]});
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
